// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- RV32I load/store unit
//
// Accepts one memory operation at a time from the execute stage, issues a
// single word-aligned request to data memory with byte enables and lane-
// replicated store data, and returns sign/zero-extended load data to
// writeback one cycle after the read data arrives.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : operation handshake (ready only in IDLE)
//   addr, wdata         : effective address, store data
//   mem_op              : funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU; others W)
//   is_store, rd_in     : store/load select, load destination tag
//   resp_valid/_rdata/_rd : registered load writeback result
//   dmem_req/_we/_addr/_be/_wdata : data-memory request (held until grant)
//   dmem_gnt, dmem_rvalid, dmem_rdata : data-memory grant and read return
//   misalign_exc        : one-cycle misaligned-access pulse
//
// Configuration
//   LSU_MISALIGN_TRAP_EN defined   : misaligned accesses are accepted, not
//                                    issued, and flagged on misalign_exc.
//   LSU_MISALIGN_TRAP_EN undefined : misalign_exc is 0; offending low
//                                    address bits are forced to zero.
// -----------------------------------------------------------------------------
module lsu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [2:0]            mem_op,
  input  logic                  is_store,
  input  logic [4:0]            rd_in,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [4:0]            resp_rd,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  misalign_exc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Access size encoding kept with the registered request
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_e      state_q, state_d;
  logic        dmem_req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [4:0]  rd_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic [4:0]  resp_rd_q;

  logic [1:0]  size_s;
  logic [1:0]  off_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic        accept_s;
  logic        issue_s;
  logic        load_done_s;

  // Shift the returned word down to the addressed lane, then extend
  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      SZ_BYTE: load_extract = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
      SZ_HALF: load_extract = uns ? {16'h0000,   sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extract = sh;
    endcase
  endfunction

  // Decode size, lane offset, byte enables and replicated store data.
  // Halfword/word offsets drop the low bits, which is exactly the forced
  // alignment used when misaligned accesses are not trapped.
  always_comb begin
    size_s  = SZ_WORD;
    off_s   = 2'b00;
    be_s    = 4'b1111;
    wdata_s = wdata;
    case (mem_op[1:0])
      2'b00: begin
        size_s  = SZ_BYTE;
        off_s   = addr[1:0];
        be_s    = 4'b0001 << addr[1:0];
        wdata_s = {4{wdata[7:0]}};
      end
      2'b01: begin
        size_s  = SZ_HALF;
        off_s   = {addr[1], 1'b0};
        be_s    = 4'b0011 << {addr[1], 1'b0};
        wdata_s = {2{wdata[15:0]}};
      end
      default: begin
        size_s  = SZ_WORD;
        off_s   = 2'b00;
        be_s    = 4'b1111;
        wdata_s = wdata;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept_s  = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_s;
  logic misalign_q;

  assign misalign_s = ((size_s == SZ_HALF) && addr[0]) ||
                      ((size_s == SZ_WORD) && (addr[1:0] != 2'b00));
  assign issue_s    = accept_s && !misalign_s;

  // Misaligned accepts stay in IDLE and raise a one-cycle exception pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= accept_s && misalign_s;
    end
  end

  assign misalign_exc = misalign_q;
`else
  assign issue_s      = accept_s;
  assign misalign_exc = 1'b0;
`endif

  // Next-state logic; a load completes on rvalid in WAIT or on rvalid
  // coinciding with the grant in REQ. rvalid is ignored for stores.
  always_comb begin
    state_d     = state_q;
    load_done_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_s) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (!dmem_gnt) begin
          state_d = REQ;
        end else if (we_q) begin
          state_d = IDLE;
        end else if (dmem_rvalid) begin
          state_d     = IDLE;
          load_done_s = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_d     = IDLE;
          load_done_s = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, captured request, memory request and writeback registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0000_0000;
      be_q         <= 4'b0000;
      wdata_q      <= 32'h0000_0000;
      off_q        <= 2'b00;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      rd_q         <= 5'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_rd_q    <= 5'd0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= (state_d == REQ);
      resp_valid_q <= load_done_s;
      if (issue_s) begin
        we_q    <= is_store;
        addr_q  <= {addr[31:2], 2'b00};
        be_q    <= be_s;
        wdata_q <= wdata_s;
        off_q   <= off_s;
        size_q  <= size_s;
        uns_q   <= mem_op[2];
        rd_q    <= rd_in;
      end
      if (load_done_s) begin
        resp_rdata_q <= load_extract(dmem_rdata, off_q, size_q, uns_q);
        resp_rd_q    <= rd_q;
      end
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_rd    = resp_rd_q;

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu
//
// Directed operations are driven on the falling edge and all outputs are
// sampled on the falling edge. Expected load results are pushed into a
// scoreboard queue at issue time and popped by a monitor whenever the DUT
// raises resp_valid.
// -----------------------------------------------------------------------------
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  mem_op;
  logic        is_store;
  logic [4:0]  rd_in;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        misalign_exc;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
  } resp_t;

  resp_t sb_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  lsu #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .addr         (addr),
    .wdata        (wdata),
    .mem_op       (mem_op),
    .is_store     (is_store),
    .rd_in        (rd_in),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_rd      (resp_rd),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .misalign_exc (misalign_exc)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: every writeback must match the oldest expected load
  always @(negedge clk) begin : monitor
    resp_t e;
    if (resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_resp", resp_valid, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check_val("resp_rdata", resp_rdata, e.rdata);
        check_val("resp_rd", resp_rd, e.rd);
      end
    end
  end

  // Bounded wait for req_ready; returns just after a falling edge
  task automatic wait_ready();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) check_val("ready_timeout", req_ready, 1'b1);
  endtask

  // One aligned/forced-aligned operation through the full handshake.
  // gnt_wait: extra cycles before grant; rv_wait: cycles after grant until
  // rvalid (0 = same cycle as grant). Starts and ends just after a negedge.
  task automatic run_op(input logic st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    resp_t e;
    wait_ready();
    req_valid = 1'b1;
    is_store  = st;
    mem_op    = op;
    addr      = a;
    wdata     = wd;
    rd_in     = rd;
    @(posedge clk);
    if (!st) begin
      e.rdata = exp_rdata;
      e.rd    = rd;
      sb_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    check_val("dmem_req", dmem_req, 1'b1);
    check_val("req_ready_busy", req_ready, 1'b0);
    check_val("dmem_addr", dmem_addr, exp_addr);
    check_val("dmem_be", dmem_be, exp_be);
    check_val("dmem_we", dmem_we, st);
    check_val("dmem_wdata", dmem_wdata, exp_wdata);
    check_val("misalign_quiet", misalign_exc, 1'b0);
    for (int i = 0; i < gnt_wait; i++) begin
      @(negedge clk);
      check_val("stall_req", dmem_req, 1'b1);
      check_val("stall_addr", dmem_addr, exp_addr);
      check_val("stall_be", dmem_be, exp_be);
      check_val("stall_wdata", dmem_wdata, exp_wdata);
      check_val("stall_ready", req_ready, 1'b0);
    end
    dmem_gnt = 1'b1;
    if (!st && rv_wait == 0) begin
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
    end
    @(negedge clk);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0000_0000;
    if (st) begin
      check_val("store_no_resp", resp_valid, 1'b0);
      check_val("store_done_ready", req_ready, 1'b1);
      check_val("store_req_drop", dmem_req, 1'b0);
    end else begin
      if (rv_wait > 0) begin
        check_val("wait_req_drop", dmem_req, 1'b0);
        check_val("wait_ready", req_ready, 1'b0);
        for (int i = 1; i < rv_wait; i++) begin
          @(negedge clk);
          check_val("wait_no_resp", resp_valid, 1'b0);
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0000_0000;
      end
      check_val("resp_pulse", resp_valid, 1'b1);
      @(negedge clk);
      check_val("resp_pulse_end", resp_valid, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    addr        = 32'h0000_0000;
    wdata       = 32'h0000_0000;
    mem_op      = 3'b000;
    is_store    = 1'b0;
    rd_in       = 5'd0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0000_0000;
    repeat (3) @(negedge clk);
    check_val("rst_ready", req_ready, 1'b0);
    check_val("rst_dmem_req", dmem_req, 1'b0);
    check_val("rst_resp_valid", resp_valid, 1'b0);
    check_val("rst_misalign", misalign_exc, 1'b0);
    check_val("rst_dmem_addr", dmem_addr, 32'h0000_0000);
    check_val("rst_dmem_be", dmem_be, 4'b0000);
    check_val("rst_dmem_wdata", dmem_wdata, 32'h0000_0000);
    check_val("rst_dmem_we", dmem_we, 1'b0);
    check_val("rst_resp_rdata", resp_rdata, 32'h0000_0000);
    check_val("rst_resp_rd", resp_rd, 5'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_ready", req_ready, 1'b1);

    // LB 0x1003, grant at T+1, rvalid at T+3
    run_op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd3, 0, 2, 32'h80FF_FFFF,
           32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80);
    // SH 0x2002
    run_op(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd0, 0, 0, 32'h0,
           32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0);
    // LHU 0x0, grant and rvalid together
    run_op(1'b0, 3'b101, 32'h0000_0000, 32'h0, 5'd7, 0, 0, 32'h0000_9876,
           32'h0000_0000, 4'b0011, 32'h0, 32'h0000_9876);
    // SW with grant held off for 5 cycles
    run_op(1'b1, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 5'd0, 5, 0, 32'h0,
           32'h0000_3000, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    // LH upper half, sign-extended
    run_op(1'b0, 3'b001, 32'h0000_1002, 32'h0, 5'd12, 1, 1, 32'h8001_0000,
           32'h0000_1000, 4'b1100, 32'h0, 32'hFFFF_8001);
    // LBU lane 1, zero-extended
    run_op(1'b0, 3'b100, 32'h0000_1001, 32'h0, 5'd31, 0, 3, 32'h0000_A500,
           32'h0000_1000, 4'b0010, 32'h0, 32'h0000_00A5);
    // SB lane 1, byte replicated
    run_op(1'b1, 3'b000, 32'h0000_0001, 32'h0000_0077, 5'd0, 2, 0, 32'h0,
           32'h0000_0000, 4'b0010, 32'h7777_7777, 32'h0);
    // funct3 011 treated as a word load
    run_op(1'b0, 3'b011, 32'h0000_0010, 32'h0, 5'd9, 0, 0, 32'h1234_5678,
           32'h0000_0010, 4'b1111, 32'h0, 32'h1234_5678);
    // LB lane 0, positive byte
    run_op(1'b0, 3'b000, 32'h0000_0100, 32'h0, 5'd1, 0, 0, 32'hFFFF_FF7F,
           32'h0000_0100, 4'b0001, 32'h0, 32'h0000_007F);

    // LW 0x1001: misaligned
`ifdef LSU_MISALIGN_TRAP_EN
    wait_ready();
    req_valid = 1'b1;
    is_store  = 1'b0;
    mem_op    = 3'b010;
    addr      = 32'h0000_1001;
    rd_in     = 5'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_val("trap_pulse", misalign_exc, 1'b1);
    check_val("trap_no_req", dmem_req, 1'b0);
    check_val("trap_ready", req_ready, 1'b1);
    @(negedge clk);
    check_val("trap_pulse_end", misalign_exc, 1'b0);
    check_val("trap_no_req2", dmem_req, 1'b0);
    check_val("trap_no_resp", resp_valid, 1'b0);
`else
    run_op(1'b0, 3'b010, 32'h0000_1001, 32'h0, 5'd4, 0, 0, 32'hCAFE_F00D,
           32'h0000_1000, 4'b1111, 32'h0, 32'hCAFE_F00D);
`endif

    // Grant/rvalid while IDLE must be ignored
    wait_ready();
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_5555;
    @(negedge clk);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    check_val("idle_ign_req", dmem_req, 1'b0);
    check_val("idle_ign_resp", resp_valid, 1'b0);
    @(negedge clk);
    check_val("idle_ign_resp2", resp_valid, 1'b0);
    check_val("idle_ign_ready", req_ready, 1'b1);

    // Reset in WAIT, then a late rvalid
    wait_ready();
    req_valid = 1'b1;
    is_store  = 1'b0;
    mem_op    = 3'b010;
    addr      = 32'h0000_4000;
    rd_in     = 5'd5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    dmem_gnt  = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check_val("wait_state_ready", req_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_wait_ready", req_ready, 1'b0);
    check_val("rst_wait_req", dmem_req, 1'b0);
    check_val("rst_wait_addr", dmem_addr, 32'h0000_0000);
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check_val("late_rv_ready", req_ready, 1'b1);
    check_val("late_rv_req", dmem_req, 1'b0);
    @(negedge clk);
    check_val("late_rv_no_resp", resp_valid, 1'b0);
    @(negedge clk);
    check_val("late_rv_no_resp2", resp_valid, 1'b0);

    // A fresh load after the abort still works
    run_op(1'b0, 3'b100, 32'h0000_0003, 32'h0, 5'd17, 0, 1, 32'hC300_0000,
           32'h0000_0000, 4'b1000, 32'h0, 32'h0000_00C3);

    repeat (2) @(negedge clk);
    check_val("sb_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data and address width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the execute stage presents a memory operation.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the LSU accepts the operation this cycle.
REQ-006 The block SHALL have port addr, input, 32 bits: the effective address, i.e. the ALU sum result.
REQ-007 The block SHALL have port wdata, input, 32 bits: the store data (rs2).
REQ-008 The block SHALL have port mem_op, input, 3 bits: the RV32I funct3 code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 The block SHALL have port is_store, input, 1 bit: 1 means store, 0 means load.
REQ-010 The block SHALL have port rd_in, input, 5 bits: the load destination register tag.
REQ-011 The block SHALL have ports resp_valid (output, 1 bit), resp_rdata (output, 32 bits) and resp_rd (output, 5 bits): the load writeback result.
REQ-012 The block SHALL have ports dmem_req, dmem_we (output, 1 bit each), dmem_addr (output, 32 bits), dmem_be (output, 4 bits) and dmem_wdata (output, 32 bits): the data-memory request.
REQ-013 The block SHALL have ports dmem_gnt, dmem_rvalid (input, 1 bit each) and dmem_rdata (input, 32 bits): the data-memory grant and read return.
REQ-014 The block SHALL have port misalign_exc, output, 1 bit: a one-cycle pulse flagging a misaligned access.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, REQ and WAIT.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 An operation SHALL be accepted on any cycle where req_valid && req_ready.
REQ-018 On acceptance in cycle T, the LSU SHALL register all request fields and enter REQ, with dmem_req=1 from cycle T+1.
REQ-019 In REQ, dmem_req and all dmem_* outputs SHALL stay stable until dmem_gnt=1.
REQ-020 A store SHALL complete on the grant cycle: return to IDLE, no resp_valid.
REQ-021 A load granted without dmem_rvalid in the same cycle SHALL move REQ->WAIT.
REQ-022 A load granted with dmem_rvalid=1 in the same cycle SHALL complete directly from REQ.
REQ-023 A load in WAIT SHALL complete on dmem_rvalid=1 and return to IDLE.
REQ-024 On load completion at cycle C, resp_valid SHALL pulse high for exactly cycle C+1, with resp_rdata and resp_rd valid in that cycle.
REQ-025 resp_rdata, resp_rd and resp_valid SHALL all be registered outputs.
REQ-026 dmem_addr SHALL be {addr[31:2], 2'b00}.
REQ-027 dmem_we SHALL equal is_store.
REQ-028 dmem_be SHALL be 4'b0001<<addr[1:0] for B/BU, 4'b0011<<{addr[1],1'b0} for H/HU, and 4'b1111 for W.
REQ-029 Store data SHALL be replicated on dmem_wdata: the byte 4x, the halfword 2x, the word as is.
REQ-030 Loads SHALL shift dmem_rdata right by 8*addr[1:0], then sign-extend (B/H), zero-extend (BU/HU), or pass through (W).
REQ-031 mem_op codes 011, 110 and 111 SHALL be treated as W.
REQ-032 dmem_rvalid and dmem_gnt SHALL be ignored in IDLE, and dmem_rvalid SHALL also be ignored in REQ for stores.
REQ-033 A transfer is misaligned when H/HU has addr[0]=1, or W has addr[1:0]!=0.

Reset
REQ-034 While rst=1, the FSM SHALL be in IDLE.
REQ-035 While rst=1, dmem_req, resp_valid and misalign_exc SHALL be 0, and resp_rdata, resp_rd, dmem_addr, dmem_be, dmem_wdata and dmem_we SHALL be 0.
REQ-036 Reset asserted in REQ or WAIT SHALL abandon the operation, with no resp_valid afterwards.
REQ-037 An rvalid arriving after such a reset SHALL be ignored.
REQ-038 req_ready SHALL be 0 while rst=1.

Configuration
REQ-039 Macro LSU_MISALIGN_TRAP_EN defined: a misaligned access SHALL be accepted, issue no dmem request and produce no resp_valid, and misalign_exc SHALL pulse at T+1 while the FSM stays in IDLE.
REQ-040 Macro LSU_MISALIGN_TRAP_EN undefined: misalign_exc SHALL be tied 0, and the offending low address bits SHALL be forced to zero (H uses {addr[1],0}; W uses 00) for dmem_be and load extraction.

Verification
REQ-041 LB, addr=0x1003, dmem_rdata=0x80FF_FF_FF, gnt at T+1, rvalid at T+3 -> dmem_addr=0x1000, be=1000, resp_rdata=0xFFFFFF80 and resp_valid at T+4 only.
REQ-042 SH, addr=0x2002, wdata=0x1234ABCD -> dmem_wdata=0xABCDABCD, be=1100, we=1, no resp_valid.
REQ-043 LHU, addr=0x0, gnt and rvalid both at T+1, rdata=0x0000_9876 -> resp_rdata=0x00009876 at T+2, resp_rd=rd_in.
REQ-044 dmem_gnt held 0 for 5 cycles -> dmem_req and dmem_* stable, req_ready=0 throughout.
REQ-045 rst pulsed in WAIT, then a late rvalid -> FSM in IDLE, no resp_valid.
REQ-046 LW, addr=0x1001 -> with LSU_MISALIGN_TRAP_EN: misalign_exc pulse, no dmem_req; without it: dmem_addr=0x1000, be=1111.
